// File: rtl/dmem_if.sv
// Load/store port between the pipeline MEM stage (master) and the data-memory responder (slave).
interface dmem_if #(
    parameter int unsigned addWidth  = 6,
    parameter int unsigned dataWidth = 32
);
    logic                 req_valid;
    logic                 req_we;
    logic [addWidth-1:0]  req_addr;
    logic [dataWidth-1:0] req_wdata;
    logic                 req_ready;
    logic                 resp_valid;
    logic [dataWidth-1:0] resp_rdata;
    logic                 stall;
    logic                 busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, stall, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, stall, busy
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: serialises one load/store at a time and answers after LATENCY cycles,
// stalling the pipeline until the one-cycle completion strobe.
module dmem_responder #(
    parameter int unsigned addWidth  = 6,
    parameter int unsigned dataWidth = 32,
    parameter int unsigned LATENCY   = 2
) (
    input logic   clk,
    input logic   reset,
    dmem_if.slave bus
);
    localparam int unsigned Words = 1 << addWidth;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 we_q;
    logic [addWidth-1:0]  addr_q;
    logic [dataWidth-1:0] wdata_q;
    logic [dataWidth-1:0] rdata_q;
    logic [dataWidth-1:0] mem [Words];

    logic                 accept;
    logic                 commit;
    logic                 acc_we;
    logic [addWidth-1:0]  acc_addr;
    logic [dataWidth-1:0] acc_wdata;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? StResp : StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = StResp;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // With LATENCY=1 the commit edge is also the accept edge, so use the live request.
    assign acc_we    = (state_q == StIdle) ? bus.req_we    : we_q;
    assign acc_addr  = (state_q == StIdle) ? bus.req_addr  : addr_q;
    assign acc_wdata = (state_q == StIdle) ? bus.req_wdata : wdata_q;
    assign commit    = (state_q != StResp) && (state_d == StResp);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= bus.req_we;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (commit) rdata_q <= acc_we ? acc_wdata : mem[acc_addr];
        end
    end

    // Array is never cleared; reset only suppresses a pending commit.
    always_ff @(posedge clk or posedge reset) begin
        if (!reset) begin
            if (commit && acc_we) mem[acc_addr] <= acc_wdata;
        end
    end

    assign bus.req_ready  = (state_q == StIdle) && !reset;
    assign bus.busy       = (state_q != StIdle);
    assign bus.resp_valid = (state_q == StResp);
    assign bus.resp_rdata = rdata_q;
    assign bus.stall      = bus.req_valid && (state_q != StResp);
endmodule
